// File: rtl/n64_vbus_tx_pkg.sv
// Shared constants and types for the N64 video-bus transmitter.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package n64_vbus_tx_pkg;

  localparam int COLOR_W = 7;
  localparam int HCNT_W  = 10;
  localparam int VCNT_W  = 9;

  // Bit positions inside the 4-bit sync nibble carried on D_o[3:0]
  localparam int SYNC_NVSYNC = 3;
  localparam int SYNC_NCLAMP = 2;
  localparam int SYNC_NHSYNC = 1;
  localparam int SYNC_NCSYNC = 0;

  // Width of one colour bar in pixels (8 bars across 640 active pixels)
  localparam int BAR_W = 80;

  localparam logic [COLOR_W-1:0] C_ZERO = 7'h00;
  localparam logic [COLOR_W-1:0] C_FULL = 7'h7F;
  localparam logic [COLOR_W-1:0] C_GREY = 7'h40;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_FLAT  = 2'd3
  } pat_sel_e;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  // Mean of two channel values: 8-bit sum, LSB dropped (truncating)
  function automatic logic [COLOR_W-1:0] blur_avg(input logic [COLOR_W-1:0] a,
                                                   input logic [COLOR_W-1:0] b);
    logic [COLOR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[COLOR_W:1];
  endfunction

endpackage

// File: rtl/n64_vbus_pattern.sv
// Test-pattern generator: RGB of active pixel x on a line of given parity.
// Latency: purely combinational.
// Backpressure: none; a pure function of its inputs.
module n64_vbus_pattern
  import n64_vbus_tx_pkg::*;
(
  input  logic [HCNT_W-1:0] x,
  input  logic              line_odd,
  input  pat_sel_e          sel,
  output rgb_t              rgb
);

  logic [2:0] bar;

  // Bar index x/80 via a compare chain instead of a divider
  always_comb begin
    bar = 3'd7;
    if      (x < HCNT_W'(1 * BAR_W)) bar = 3'd0;
    else if (x < HCNT_W'(2 * BAR_W)) bar = 3'd1;
    else if (x < HCNT_W'(3 * BAR_W)) bar = 3'd2;
    else if (x < HCNT_W'(4 * BAR_W)) bar = 3'd3;
    else if (x < HCNT_W'(5 * BAR_W)) bar = 3'd4;
    else if (x < HCNT_W'(6 * BAR_W)) bar = 3'd5;
    else if (x < HCNT_W'(7 * BAR_W)) bar = 3'd6;
  end

  // Select the colour triple for the requested pattern
  always_comb begin
    rgb = '0;
    case (sel)
      PAT_BARS: begin
        rgb.r = bar[2] ? C_FULL : C_ZERO;
        rgb.g = bar[1] ? C_FULL : C_ZERO;
        rgb.b = bar[0] ? C_FULL : C_ZERO;
      end
      PAT_RAMP: begin
        rgb.r = x[COLOR_W-1:0];
        rgb.g = x[COLOR_W-1:0];
        rgb.b = x[COLOR_W-1:0];
      end
      PAT_CHECK: begin
        if (x[0] ^ line_odd) rgb = '{r: C_FULL, g: C_FULL, b: C_FULL};
      end
      PAT_FLAT: rgb = '{r: C_GREY, g: C_GREY, b: C_GREY};
      default: rgb = '0;
    endcase
  end

endmodule

// File: rtl/n64_vbus_tx.sv
// N64 VI-side bus source: nDSYNC plus sync/R/G/B words over a 240p raster.
// Latency: every output registered; one word per VCLK, four words per pixel.
// Backpressure: none; free-running, config only changes at frame boundaries.
module n64_vbus_tx
  import n64_vbus_tx_pkg::*;
#(
  parameter int H_TOTAL     = 773,
  parameter int H_SYNC_LEN  = 57,
  parameter int H_ACT_START = 108,
  parameter int H_ACT_LEN   = 640,
  parameter int V_TOTAL     = 263,
  parameter int V_SYNC_LEN  = 3,
  parameter int V_ACT_START = 20,
  parameter int V_ACT_LEN   = 240
)(
  input  logic               VCLK,
  input  logic               nRST,
  input  logic               en_i,
  input  logic [1:0]         pattern_sel_i,
  input  logic               blur_en_i,
  output logic               nDSYNC_o,
  output logic [COLOR_W-1:0] D_o,
  output logic               frame_start_o
);

  localparam logic [HCNT_W-1:0] ONE_H      = HCNT_W'(1);
  localparam logic [VCNT_W-1:0] ONE_V      = VCNT_W'(1);
  localparam logic [HCNT_W-1:0] H_LAST     = HCNT_W'(H_TOTAL - 1);
  localparam logic [HCNT_W-1:0] H_SYNC_END = HCNT_W'(H_SYNC_LEN);
  localparam logic [HCNT_W-1:0] H_ACT_S    = HCNT_W'(H_ACT_START);
  localparam logic [HCNT_W-1:0] H_ACT_E    = HCNT_W'(H_ACT_START + H_ACT_LEN);
  localparam logic [HCNT_W-1:0] X_LAST     = HCNT_W'(H_ACT_LEN - 1);
  localparam logic [VCNT_W-1:0] V_LAST     = VCNT_W'(V_TOTAL - 1);
  localparam logic [VCNT_W-1:0] V_SYNC_END = VCNT_W'(V_SYNC_LEN);
  localparam logic [VCNT_W-1:0] V_ACT_S    = VCNT_W'(V_ACT_START);
  localparam logic [VCNT_W-1:0] V_ACT_E    = VCNT_W'(V_ACT_START + V_ACT_LEN);

  // ph is the phase of the word launched on the next edge, so the sync
  // word of pixel (0,0) is the first thing out of reset.
  logic [1:0]        ph;
  logic [HCNT_W-1:0] hcnt;
  logic [VCNT_W-1:0] vcnt;
  logic              run;
  pat_sel_e          sel_sh;
  logic              blur_sh;

  logic              h_wrap;
  logic              frame_wrap;
  logic [3:0]        sync_nib;
  logic              n_hsync;
  logic              n_vsync;
  logic              n_clamp;
  logic              active;
  logic [HCNT_W-1:0] x;
  logic [HCNT_W-1:0] x_prev;
  logic [HCNT_W-1:0] x_next;
  rgb_t              p_cur;
  rgb_t              p_prev;
  rgb_t              p_next;
  rgb_t              blur_rgb;
  rgb_t              pix;

  assign h_wrap     = (ph == 2'd3) && (hcnt == H_LAST);
  assign frame_wrap = h_wrap && (vcnt == V_LAST);

  // Raster counters; run and pattern/blur shadows reload only at frame wrap
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      ph      <= 2'd0;
      hcnt    <= '0;
      vcnt    <= '0;
      run     <= 1'b0;
      sel_sh  <= PAT_BARS;
      blur_sh <= 1'b0;
    end else begin
      ph <= ph + 2'd1;
      if (ph == 2'd3) hcnt <= (hcnt == H_LAST) ? '0 : hcnt + ONE_H;
      if (h_wrap)     vcnt <= (vcnt == V_LAST) ? '0 : vcnt + ONE_V;
      if (frame_wrap) begin
        run     <= en_i;
        sel_sh  <= pat_sel_e'(pattern_sel_i);
        blur_sh <= blur_en_i;
      end
    end
  end

  assign n_hsync = !(hcnt < H_SYNC_END);
  assign n_vsync = !(vcnt < V_SYNC_END);
  assign n_clamp = !((hcnt >= H_SYNC_END) && (hcnt < H_ACT_S));

  // Sync nibble; composite sync inverts during the vertical sync lines
  always_comb begin
    sync_nib = 4'hF;
    if (run) begin
      sync_nib[SYNC_NVSYNC] = n_vsync;
      sync_nib[SYNC_NCLAMP] = n_clamp;
      sync_nib[SYNC_NHSYNC] = n_hsync;
      sync_nib[SYNC_NCSYNC] = n_vsync ? n_hsync : ~n_hsync;
    end
  end

  assign active = (hcnt >= H_ACT_S) && (hcnt < H_ACT_E) &&
                  (vcnt >= V_ACT_S) && (vcnt < V_ACT_E);
  assign x      = hcnt - H_ACT_S;
  assign x_prev = x - ONE_H;
  // The last odd pixel has no right-hand neighbour; mirror the left one
  assign x_next = (x == X_LAST) ? x_prev : x + ONE_H;

  n64_vbus_pattern u_pat_cur (
    .x        (x),
    .line_odd (vcnt[0]),
    .sel      (sel_sh),
    .rgb      (p_cur)
  );

  n64_vbus_pattern u_pat_prev (
    .x        (x_prev),
    .line_odd (vcnt[0]),
    .sel      (sel_sh),
    .rgb      (p_prev)
  );

  n64_vbus_pattern u_pat_next (
    .x        (x_next),
    .line_odd (vcnt[0]),
    .sel      (sel_sh),
    .rgb      (p_next)
  );

  // Neighbour average for odd pixels when blur emulation is on
  always_comb begin
    blur_rgb.r = blur_avg(p_prev.r, p_next.r);
    blur_rgb.g = blur_avg(p_prev.g, p_next.g);
    blur_rgb.b = blur_avg(p_prev.b, p_next.b);
  end

  // Pixel colour: black outside the active window or while idle
  always_comb begin
    pix = '0;
    if (run && active) pix = (blur_sh && x[0]) ? blur_rgb : p_cur;
  end

  // Output word register: sync word on phase 0, then R, G, B
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      nDSYNC_o      <= 1'b1;
      D_o           <= '0;
      frame_start_o <= 1'b0;
    end else begin
      case (ph)
        2'd0: begin
          nDSYNC_o      <= 1'b0;
          D_o           <= {3'b000, sync_nib};
          frame_start_o <= run && (hcnt == '0) && (vcnt == '0);
        end
        2'd1: begin
          nDSYNC_o      <= 1'b1;
          D_o           <= pix.r;
          frame_start_o <= 1'b0;
        end
        2'd2: begin
          nDSYNC_o      <= 1'b1;
          D_o           <= pix.g;
          frame_start_o <= 1'b0;
        end
        default: begin
          nDSYNC_o      <= 1'b1;
          D_o           <= pix.b;
          frame_start_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_n64_vbus_tx.sv
// Bench for n64_vbus_tx on a reduced raster (short frames, same horizontal sync layout).
// Every output word is compared against a raster model; fixed vectors pin key words.
// Inputs are driven on the falling edge, outputs sampled 1 time unit after the rising edge.
module tb_n64_vbus_tx;

  localparam int HT = 200;
  localparam int HS = 57;
  localparam int HA = 108;
  localparam int HL = 84;
  localparam int VT = 10;
  localparam int VS = 3;
  localparam int VA = 4;
  localparam int VL = 5;
  localparam int FRAME = 4 * HT * VT;
  localparam int NT = 31;

  logic       VCLK = 1'b0;
  logic       nRST = 1'b0;
  logic       en_i = 1'b0;
  logic [1:0] pattern_sel_i = 2'd0;
  logic       blur_en_i = 1'b0;
  logic       nDSYNC_o;
  logic [6:0] D_o;
  logic       frame_start_o;

  n64_vbus_tx #(
    .H_TOTAL(HT), .H_SYNC_LEN(HS), .H_ACT_START(HA), .H_ACT_LEN(HL),
    .V_TOTAL(VT), .V_SYNC_LEN(VS), .V_ACT_START(VA), .V_ACT_LEN(VL)
  ) dut (
    .VCLK          (VCLK),
    .nRST          (nRST),
    .en_i          (en_i),
    .pattern_sel_i (pattern_sel_i),
    .blur_en_i     (blur_en_i),
    .nDSYNC_o      (nDSYNC_o),
    .D_o           (D_o),
    .frame_start_o (frame_start_o)
  );

  always #5 VCLK = ~VCLK;

  typedef struct {
    int f; int l; int p; int ph;
    int nds; int d; int fs;
  } vec_t;

  vec_t tbl [NT];
  int   checks = 0;
  int   failures = 0;
  int   hits = 0;
  int   era = 0;

  // model state: word index since reset release and per-frame config
  int k = 0;
  int m_run = 0;
  int m_sel = 0;
  int m_blur = 0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // pattern value of channel ch (0=R,1=G,2=B) at active pixel x on line v
  function automatic int pat(input int sel, input int x, input int v, input int ch);
    case (sel)
      0:       return (((x / 80) >> (2 - ch)) & 1) ? 127 : 0;
      1:       return x % 128;
      2:       return ((x + v) % 2) ? 127 : 0;
      default: return 64;
    endcase
  endfunction

  function automatic int colour(input int sel, input int blur, input int x,
                                input int v, input int ch);
    int l;
    int r;
    if (blur != 0 && (x % 2) == 1) begin
      l = pat(sel, x - 1, v, ch);
      r = (x == HL - 1) ? l : pat(sel, x + 1, v, ch);
      return (l + r) / 2;
    end
    return pat(sel, x, v, ch);
  endfunction

  // expected {nDSYNC, D, frame_start} packed as nds<<8 | d<<1 | fs
  function automatic int model_word(input int kk, input int run, input int sel, input int blur);
    int ph; int p; int h; int v; int d; int nh; int nv; int nc; int cs; int act;
    ph = kk % 4;
    p  = kk / 4;
    h  = p % HT;
    v  = (p / HT) % VT;
    if (ph == 0) begin
      if (run == 0) d = 15;
      else begin
        nh = (h >= HS) ? 1 : 0;
        nv = (v >= VS) ? 1 : 0;
        nc = (h >= HS && h < HA) ? 0 : 1;
        cs = (nv != 0) ? nh : 1 - nh;
        d  = nv * 8 + nc * 4 + nh * 2 + cs;
      end
      return (d << 1) | ((run != 0 && h == 0 && v == 0) ? 1 : 0);
    end
    act = (run != 0 && h >= HA && h < HA + HL && v >= VA && v < VA + VL) ? 1 : 0;
    d = (act != 0) ? colour(sel, blur, h - HA, v, ph - 1) : 0;
    return (1 << 8) | (d << 1);
  endfunction

  // Continuous checker: every emitted word against the model, plus fixed vectors
  always @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      k = 0; m_run = 0; m_sel = 0; m_blur = 0;
    end else begin
      #1;
      if (nRST) begin
        chk($sformatf("word era%0d k=%0d", era, k),
            {23'd0, nDSYNC_o, D_o, frame_start_o}, model_word(k, m_run, m_sel, m_blur));
        if (era == 0) begin
          for (int i = 0; i < NT; i++) begin
            if (tbl[i].f * FRAME + ((tbl[i].l * HT) + tbl[i].p) * 4 + tbl[i].ph == k) begin
              hits++;
              chk($sformatf("vec%0d f%0d l%0d p%0d ph%0d", i, tbl[i].f, tbl[i].l, tbl[i].p, tbl[i].ph),
                  {23'd0, nDSYNC_o, D_o, frame_start_o},
                  (tbl[i].nds << 8) | (tbl[i].d << 1) | tbl[i].fs);
            end
          end
        end
        if (k % FRAME == FRAME - 1) begin
          m_run = int'(en_i); m_sel = int'(pattern_sel_i); m_blur = int'(blur_en_i);
        end
        k++;
      end
    end
  end

  // One frame of random mid-frame config churn, ending on the planned config
  task automatic frame_with_plan(input logic en, input logic [1:0] sel, input logic blur);
    for (int c = 0; c < FRAME; c++) begin
      if (c >= FRAME - 20) begin
        en_i = en; pattern_sel_i = sel; blur_en_i = blur;
      end else if ($urandom_range(15) == 0) begin
        en_i          = 1'($urandom_range(1));
        pattern_sel_i = 2'($urandom_range(3));
        blur_en_i     = 1'($urandom_range(1));
      end
      @(negedge VCLK);
    end
  endtask

  initial begin
    int n;
    //        f  l    p  ph nds  d     fs
    tbl[0]  = '{0, 0,   0, 0, 0, 'h0F, 0};
    tbl[1]  = '{0, 5, 110, 1, 1, 'h00, 0};
    tbl[2]  = '{1, 0,   0, 0, 0, 'h05, 1};
    tbl[3]  = '{1, 0,  56, 0, 0, 'h05, 0};
    tbl[4]  = '{1, 0,  57, 0, 0, 'h02, 0};
    tbl[5]  = '{1, 0, 107, 0, 0, 'h02, 0};
    tbl[6]  = '{1, 0, 108, 0, 0, 'h06, 0};
    tbl[7]  = '{1, 5,  60, 0, 0, 'h0B, 0};
    tbl[8]  = '{1, 8,   0, 0, 0, 'h0C, 0};
    tbl[9]  = '{1, 5, 108, 1, 1, 'h40, 0};
    tbl[10] = '{1, 5, 191, 3, 1, 'h40, 0};
    tbl[11] = '{1, 5, 192, 2, 1, 'h00, 0};
    tbl[12] = '{1, 3, 120, 1, 1, 'h00, 0};
    tbl[13] = '{1, 9, 120, 1, 1, 'h00, 0};
    tbl[14] = '{1, 4, 107, 1, 1, 'h00, 0};
    tbl[15] = '{2, 4, 113, 1, 1, 'h05, 0};
    tbl[16] = '{2, 4, 112, 2, 1, 'h04, 0};
    tbl[17] = '{2, 6, 191, 3, 1, 'h52, 0};
    tbl[18] = '{3, 4, 108, 1, 1, 'h00, 0};
    tbl[19] = '{3, 4, 109, 1, 1, 'h7F, 0};
    tbl[20] = '{3, 5, 108, 1, 1, 'h7F, 0};
    tbl[21] = '{4, 4, 109, 2, 1, 'h00, 0};
    tbl[22] = '{4, 5, 109, 2, 1, 'h7F, 0};
    tbl[23] = '{4, 4, 108, 3, 1, 'h00, 0};
    tbl[24] = '{5, 4, 187, 1, 1, 'h00, 0};
    tbl[25] = '{5, 4, 187, 3, 1, 'h3F, 0};
    tbl[26] = '{5, 4, 188, 3, 1, 'h7F, 0};
    tbl[27] = '{5, 4, 188, 1, 1, 'h00, 0};
    tbl[28] = '{6, 0,   0, 0, 0, 'h0F, 0};
    tbl[29] = '{6, 0,  30, 0, 0, 'h0F, 0};
    tbl[30] = '{6, 0, 120, 1, 1, 'h00, 0};

    repeat (3) @(negedge VCLK);
    chk("reset_idle", {23'd0, nDSYNC_o, D_o, frame_start_o}, 'h100);
    nRST = 1'b1;

    frame_with_plan(1'b1, 2'd3, 1'b0); // f0 idle -> flat
    frame_with_plan(1'b1, 2'd1, 1'b1); // f1 flat -> ramp+blur
    frame_with_plan(1'b1, 2'd2, 1'b0); // f2 ramp+blur -> checker
    frame_with_plan(1'b1, 2'd2, 1'b1); // f3 checker -> checker+blur
    frame_with_plan(1'b1, 2'd0, 1'b1); // f4 checker+blur -> bars+blur
    frame_with_plan(1'b0, 2'd3, 1'b0); // f5 bars+blur -> idle

    // f6 idle: run up to the sync word of pixel 10 on line 1
    for (int c = 0; c < 841; c++) begin
      if ($urandom_range(7) == 0) pattern_sel_i = 2'($urandom_range(3));
      @(negedge VCLK);
    end
    chk("pre_reset_word", {23'd0, nDSYNC_o, D_o, frame_start_o}, 'h01E);

    // asynchronous reset between clock edges
    era = 1;
    nRST = 1'b0;
    #1;
    chk("async_reset", {23'd0, nDSYNC_o, D_o, frame_start_o}, 'h100);
    en_i = 1'b1; pattern_sel_i = 2'd3; blur_en_i = 1'b0;
    repeat (3) @(negedge VCLK);
    chk("reset_hold", {23'd0, nDSYNC_o, D_o, frame_start_o}, 'h100);
    nRST = 1'b1;

    @(posedge VCLK); #1;
    chk("first_word_after_release", {23'd0, nDSYNC_o, D_o, frame_start_o}, 'h01E);
    n = 1;
    while (!frame_start_o && n < 2 * FRAME) begin
      @(posedge VCLK); #1;
      n++;
    end
    chk("frame_start_edge_count", n, FRAME + 1);
    repeat (8) @(negedge VCLK);

    chk("vector_hits", hits, NT);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
